bram_tester: RTL and testbench
==============================

Name: bram_tester

Overview:
- Self-checking memory exerciser that sits directly upstream of the bram block and drives its write and read ports.
- On a start strobe it runs two phases:
  - writes a deterministic arithmetic pattern to every address;
  - reads every address back and compares each word against the regenerated pattern.
- Reports busy, done, pass/fail and the first failing address. These feed the LED status logic of the physical bench.

Parameters:
- DATA_SZ, 16: data word width. Must match the attached bram.
- ADDR_SZ, 8: address width. The test covers 2^ADDR_SZ words.
- SEED, 5: pattern value at address 0, truncated to DATA_SZ.
- STEP, 13: pattern increment per address, truncated to DATA_SZ.

Ports:
- i_clk  in  1  system clock; all state changes on its rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_start  in  1  start strobe, sampled only in IDLE or DONE
- o_busy  out  1  high while a test is running
- o_done  out  1  high from test completion until the next accepted start
- o_pass  out  1  valid while o_done is high; 1 = all words matched
- o_err_addr  out  ADDR_SZ  first mismatching address; 0 if none
- o_wr_en  out  1  bram write enable
- o_waddr  out  ADDR_SZ  bram write address
- o_wdata  out  DATA_SZ  bram write data
- o_raddr  out  ADDR_SZ  bram read address
- i_rdata  in  DATA_SZ  bram read data, valid one clock after o_raddr is presented

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state = IDLE;
  - all outputs 0, including o_wr_en, o_busy, o_done, o_pass, o_err_addr, o_waddr, o_wdata, o_raddr.
- Reset mid-test aborts immediately. No further writes are issued.
- Pattern: P(a) = (SEED + a*STEP) mod 2^DATA_SZ. It is generated incrementally by adding STEP each address; no multiplier.
- States:
  - IDLE: wait for a start.
  - WRITE: on entry the address counter is 0.
    - Each cycle: o_wr_en=1, o_waddr=a, o_wdata=P(a), then a increments.
    - After address 2^ADDR_SZ-1 is written, go to READ with a=0 and o_wr_en=0 the next cycle.
    - Write phase lasts exactly 2^ADDR_SZ cycles.
  - READ: o_raddr=a every cycle, a increments.
    - Compare is pipelined. The expected value and a valid bit are delayed one cycle, and i_rdata is compared against P(a-1) in the cycle after address a-1 was presented.
    - After the last address is presented, one drain cycle (CHECK) performs the final compare.
    - Read phase lasts 2^ADDR_SZ+1 cycles.
  - DONE: o_busy=0, o_done=1.
    - o_pass and o_err_addr are held stable until the next accepted start.
- Start acceptance:
  - i_start=1 in IDLE or DONE begins the test in the next cycle: WRITE, o_busy=1, o_done=0, o_pass=0, o_err_addr=0.
  - i_start while busy is ignored.
- First mismatch:
  - o_err_addr latches the failing address.
  - The test stops and goes to DONE the next cycle with o_pass=0. Later addresses are not checked.
- No mismatch: DONE with o_pass=1 and o_err_addr=0.
- Total latency from start acceptance to o_done rising, no error: 2*2^ADDR_SZ+2 cycles.
- Counter wrap:
  - The address counter is ADDR_SZ bits. Phase end is detected by the all-ones address, not by overflow.
  - Pattern arithmetic wraps modulo 2^DATA_SZ silently.
- o_wr_en is never high outside WRITE.
- o_raddr holds its last value outside READ.

Optional Feature:
- Macro: BRAM_TESTER_INV_EN.
- Defined: after the normal read phase passes, a second WRITE/READ pass runs using the inverted pattern ~P(a).
  - Same timing and same error reporting.
  - No-error latency doubles to 4*2^ADDR_SZ+4 cycles.
  - o_pass=1 only if both passes match.
- Not defined: single pass only. No inversion logic or pass flag is synthesized.

Test Plan:
1. ADDR_SZ=5, DATA_SZ=13, ideal bram model, start pulse:
   - 32 consecutive writes with (waddr,wdata) = (0,5), (1,18), (2,31) … (31,408);
   - then o_done=1, o_pass=1, o_err_addr=0 exactly 66 cycles after start acceptance.
2. Bram model corrupts address 9 (returns 0):
   - o_done=1, o_pass=0, o_err_addr=9;
   - no read of address 11 is ever issued.
3. i_start held high for the entire test:
   - exactly one test runs;
   - a new test begins the cycle after DONE is entered.
4. Assert i_rst_n=0 in the middle of the write phase (address 12):
   - all outputs 0 asynchronously, o_wr_en=0;
   - after release the block stays in IDLE until a start.
5. DATA_SZ=4, SEED=15, STEP=1: wdata sequence is 15, 0, 1, … (modulo wrap), and the test passes.
6. With BRAM_TESTER_INV_EN, ADDR_SZ=5, DATA_SZ=13:
   - the second pass writes 8186 at address 0;
   - o_done rises after 132 cycles with o_pass=1;
   - with a stuck-at-0 bit 0 at address 3, the test fails with o_err_addr=3.

Source files
------------

// File: rtl/bram_tester_if.sv
// bram_tester_if: status handshake and bram port bundle.
// master = tester side, slave = bench/bram side.
interface bram_tester_if #(
    parameter int DATA_SZ = 16,
    parameter int ADDR_SZ = 8
) ();
    logic               i_start;
    logic               o_busy;
    logic               o_done;
    logic               o_pass;
    logic [ADDR_SZ-1:0] o_err_addr;
    logic               o_wr_en;
    logic [ADDR_SZ-1:0] o_waddr;
    logic [DATA_SZ-1:0] o_wdata;
    logic [ADDR_SZ-1:0] o_raddr;
    logic [DATA_SZ-1:0] i_rdata;

    modport master (
        input  i_start, i_rdata,
        output o_busy, o_done, o_pass, o_err_addr,
        output o_wr_en, o_waddr, o_wdata, o_raddr
    );

    modport slave (
        output i_start, i_rdata,
        input  o_busy, o_done, o_pass, o_err_addr,
        input  o_wr_en, o_waddr, o_wdata, o_raddr
    );
endinterface

// File: rtl/bram_tester.sv
// bram_tester: write/read-back pattern exerciser for a bram.
// Optional BRAM_TESTER_INV_EN adds a second pass with ~pattern.
module bram_tester #(
    parameter int DATA_SZ = 16,
    parameter int ADDR_SZ = 8,
    parameter int SEED    = 5,
    parameter int STEP    = 13
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    bram_tester_if.master  bus
);
    localparam logic [DATA_SZ-1:0] SEED_V = DATA_SZ'(SEED);
    localparam logic [DATA_SZ-1:0] STEP_V = DATA_SZ'(STEP);
    localparam logic [ADDR_SZ-1:0] LAST   = '1;
    localparam logic [ADDR_SZ-1:0] ONE    = ADDR_SZ'(1);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        CHECK,
`ifdef BRAM_TESTER_INV_EN
        RESTART,
`endif
        DONE
    } state_t;

    state_t             state, state_nx;
    logic [ADDR_SZ-1:0] addr, ea_q, raddr_q, err_addr;
    logic [DATA_SZ-1:0] pat, exp_q, inv_mask;
    logic               vld_q, pass, miss, at_last;

`ifdef BRAM_TESTER_INV_EN
    logic inv;
    assign inv_mask = {DATA_SZ{inv}};
`else
    assign inv_mask = '0;
`endif

    assign at_last = (addr == LAST);
    assign miss    = vld_q && (bus.i_rdata != exp_q);

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Next-state: stop on first mismatch, drain one cycle after last read.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE, DONE: if (bus.i_start) state_nx = WRITE;
            WRITE:      if (at_last) state_nx = READ;
            READ: begin
                if (miss)         state_nx = DONE;
                else if (at_last) state_nx = CHECK;
            end
            CHECK: begin
                state_nx = DONE;
`ifdef BRAM_TESTER_INV_EN
                if (!miss && !inv) state_nx = RESTART;
`endif
            end
`ifdef BRAM_TESTER_INV_EN
            RESTART:    state_nx = WRITE;
`endif
            default:    state_nx = IDLE;
        endcase
    end

    // Address/pattern counters, delayed compare pipe and result flags.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            addr     <= '0;
            pat      <= '0;
            exp_q    <= '0;
            ea_q     <= '0;
            vld_q    <= 1'b0;
            raddr_q  <= '0;
            err_addr <= '0;
            pass     <= 1'b0;
`ifdef BRAM_TESTER_INV_EN
            inv      <= 1'b0;
`endif
        end else begin
            vld_q <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (bus.i_start) begin
                        addr     <= '0;
                        pat      <= SEED_V;
                        pass     <= 1'b0;
                        err_addr <= '0;
`ifdef BRAM_TESTER_INV_EN
                        inv      <= 1'b0;
`endif
                    end
                end
                WRITE: begin
                    addr <= addr + ONE;
                    pat  <= at_last ? SEED_V : pat + STEP_V;
                end
                READ: begin
                    exp_q   <= pat ^ inv_mask;
                    vld_q   <= 1'b1;
                    ea_q    <= addr;
                    raddr_q <= addr;
                    addr    <= addr + ONE;
                    pat     <= pat + STEP_V;
                    if (miss) err_addr <= ea_q;
                end
                CHECK: begin
                    if (miss) err_addr <= ea_q;
`ifdef BRAM_TESTER_INV_EN
                    else if (inv) pass <= 1'b1;
`else
                    else pass <= 1'b1;
`endif
                end
`ifdef BRAM_TESTER_INV_EN
                RESTART: begin
                    inv  <= 1'b1;
                    addr <= '0;
                    pat  <= SEED_V;
                end
`endif
                default: ;
            endcase
        end
    end

    // Outputs decoded from state; raddr holds its last value outside READ.
    always_comb begin
        bus.o_busy     = (state != IDLE) && (state != DONE);
        bus.o_done     = (state == DONE);
        bus.o_pass     = pass;
        bus.o_err_addr = err_addr;
        bus.o_wr_en    = (state == WRITE);
        bus.o_waddr    = (state == WRITE) ? addr : '0;
        bus.o_wdata    = (state == WRITE) ? (pat ^ inv_mask) : '0;
        bus.o_raddr    = (state == READ) ? addr : raddr_q;
    end
endmodule

// File: tb/tb_bram_tester.sv
// tb_bram_tester: directed tests with a write scoreboard and bram models.
// Expectations adapt when BRAM_TESTER_INV_EN is defined.
module tb_bram_tester;
`ifdef BRAM_TESTER_INV_EN
    localparam int PASSES = 2;
`else
    localparam int PASSES = 1;
`endif
    localparam int LAT = PASSES * 66;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    bram_tester_if #(.DATA_SZ(13), .ADDR_SZ(5)) ia ();
    bram_tester_if #(.DATA_SZ(4),  .ADDR_SZ(5)) ib ();

    bram_tester #(.DATA_SZ(13), .ADDR_SZ(5), .SEED(5), .STEP(13)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .bus(ia)
    );
    bram_tester #(.DATA_SZ(4), .ADDR_SZ(5), .SEED(15), .STEP(1)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .bus(ib)
    );

    // bram models: registered read, optional fault on one address
    logic [12:0] mem_a [32];
    logic [12:0] rd_a;
    logic [4:0]  rq_a;
    logic [3:0]  mem_b [32];
    logic [3:0]  rd_b;
    int          fault_mode;
    logic [4:0]  fault_addr;
    logic        saw11;

    always @(posedge clk) begin
        if (ia.o_wr_en) mem_a[ia.o_waddr] <= ia.o_wdata;
        rd_a <= mem_a[ia.o_raddr];
        rq_a <= ia.o_raddr;
        if (ib.o_wr_en) mem_b[ib.o_waddr] <= ib.o_wdata;
        rd_b <= mem_b[ib.o_raddr];
    end

    always_comb begin
        ia.i_rdata = rd_a;
        if (rq_a == fault_addr && fault_mode == 1) ia.i_rdata = '0;
        if (rq_a == fault_addr && fault_mode == 2) ia.i_rdata = rd_a & 13'h1ffe;
        ib.i_rdata = rd_b;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // write scoreboards: {addr, data}
    logic [31:0] qa [$];
    logic [31:0] qb [$];

    task automatic push_a(input int inv);
        for (int a = 0; a < 32; a++) begin
            int p;
            p = (5 + a * 13) % 8192;
            if (inv != 0) p = 8191 - p;
            qa.push_back(32'((a << 16) | p));
        end
    endtask

    task automatic push_b(input int inv);
        for (int a = 0; a < 32; a++) begin
            int p;
            p = (15 + a) % 16;
            if (inv != 0) p = 15 - p;
            qb.push_back(32'((a << 16) | p));
        end
    endtask

    task automatic push_run_a();
        for (int k = 0; k < PASSES; k++) push_a(k);
    endtask

    always @(negedge clk) begin
        if (ia.o_raddr == 5'd11) saw11 <= 1'b1;
        if (rst_n && ia.o_wr_en) begin
            logic [31:0] e;
            e = (qa.size() != 0) ? qa.pop_front() : 32'hffff_ffff;
            chk("a_write", (32'(ia.o_waddr) << 16) | 32'(ia.o_wdata), e);
        end
        if (rst_n && ib.o_wr_en) begin
            logic [31:0] e;
            e = (qb.size() != 0) ? qb.pop_front() : 32'hffff_ffff;
            chk("b_write", (32'(ib.o_waddr) << 16) | 32'(ib.o_wdata), e);
        end
    end

    task automatic pulse(input bit b, input bit hold);
        @(negedge clk);
        if (b) ib.i_start = 1'b1;
        else   ia.i_start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) begin
            ia.i_start = 1'b0;
            ib.i_start = 1'b0;
        end
    endtask

    task automatic wait_done(input bit b, output int lat);
        int n;
        logic d;
        n = 0;
        d = 1'b0;
        while (!d && n < 400) begin
            @(posedge clk);
            #1;
            n++;
            d = b ? ib.o_done : ia.o_done;
        end
        chk("done_timeout", 32'(d), 1);
        lat = n + 1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"},  32'(ia.o_busy), 0);
        chk({tag, "_done"},  32'(ia.o_done), 0);
        chk({tag, "_pass"},  32'(ia.o_pass), 0);
        chk({tag, "_err"},   32'(ia.o_err_addr), 0);
        chk({tag, "_wr_en"}, 32'(ia.o_wr_en), 0);
        chk({tag, "_waddr"}, 32'(ia.o_waddr), 0);
        chk({tag, "_wdata"}, 32'(ia.o_wdata), 0);
        chk({tag, "_raddr"}, 32'(ia.o_raddr), 0);
    endtask

    initial begin
        int lat;
        int n;
        rst_n = 1'b0;
        ia.i_start = 1'b0;
        ib.i_start = 1'b0;
        fault_mode = 0;
        fault_addr = 5'd0;
        saw11 = 1'b0;
        #12;
        chk_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // 1: clean run, latency
        push_run_a();
        pulse(1'b0, 1'b0);
        wait_done(1'b0, lat);
        chk("t1_latency", 32'(lat), LAT);
        chk("t1_pass", 32'(ia.o_pass), 1);
        chk("t1_err", 32'(ia.o_err_addr), 0);
        chk("t1_busy", 32'(ia.o_busy), 0);
        chk("t1_q_empty", 32'(qa.size()), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("t1_hold_pass", 32'(ia.o_pass), 1);
        chk("t1_hold_raddr", 32'(ia.o_raddr), 31);

        // 2: address 9 reads back 0
        fault_mode = 1;
        fault_addr = 5'd9;
        saw11 = 1'b0;
        push_a(0);
        pulse(1'b0, 1'b0);
        wait_done(1'b0, lat);
        chk("t2_pass", 32'(ia.o_pass), 0);
        chk("t2_err", 32'(ia.o_err_addr), 9);
        chk("t2_no_read11", 32'(saw11), 0);
        chk("t2_q_empty", 32'(qa.size()), 0);
        fault_mode = 0;

        // 3: start held high through a whole test
        push_run_a();
        push_run_a();
        pulse(1'b0, 1'b1);
        wait_done(1'b0, lat);
        chk("t3_latency", 32'(lat), LAT);
        @(posedge clk);
        #1;
        chk("t3_restart_busy", 32'(ia.o_busy), 1);
        chk("t3_restart_done", 32'(ia.o_done), 0);
        chk("t3_restart_waddr", 32'(ia.o_waddr), 0);
        ia.i_start = 1'b0;
        wait_done(1'b0, lat);
        chk("t3_pass", 32'(ia.o_pass), 1);
        chk("t3_q_empty", 32'(qa.size()), 0);

        // 4: reset during write of address 12
        push_run_a();
        pulse(1'b0, 1'b0);
        n = 0;
        while (!(ia.o_wr_en && ia.o_waddr == 5'd12) && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t4_reach12", 32'(ia.o_waddr), 12);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("t4_async");
        qa.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk_zero("t4_idle");

        // 5: 4-bit data wraps, DUT b
        for (int k = 0; k < PASSES; k++) push_b(k);
        pulse(1'b1, 1'b0);
        wait_done(1'b1, lat);
        chk("t5_latency", 32'(lat), LAT);
        chk("t5_pass", 32'(ib.o_pass), 1);
        chk("t5_err", 32'(ib.o_err_addr), 0);
        chk("t5_q_empty", 32'(qb.size()), 0);

        // 6: bit 0 stuck at 0 on address 3
        fault_mode = 2;
        fault_addr = 5'd3;
        push_run_a();
        pulse(1'b0, 1'b0);
        wait_done(1'b0, lat);
`ifdef BRAM_TESTER_INV_EN
        chk("t6_pass", 32'(ia.o_pass), 0);
        chk("t6_err", 32'(ia.o_err_addr), 3);
`else
        chk("t6_pass", 32'(ia.o_pass), 1);
        chk("t6_err", 32'(ia.o_err_addr), 0);
`endif
        chk("t6_q_empty", 32'(qa.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
